sobel_stream: RTL and testbench

SOBEL_STREAM -- requirements
Module: sobel_stream

---
 rtl/sobel_pkg.sv | 23 ++
 rtl/sobel_linebuf.sv | 31 +++
 rtl/sobel_stream.sv | 144 ++++++++++++++
 tb/tb_sobel_stream.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// sobel_pkg: kernel-select encodings and width/limit helpers shared by the Sobel stream block.
// Rev 1.0
package sobel_pkg;

  localparam logic [2:0] MODE_GX    = 3'd0;
  localparam logic [2:0] MODE_GY    = 3'd1;
  localparam logic [2:0] MODE_D45   = 3'd2;
  localparam logic [2:0] MODE_D135  = 3'd3;
  localparam logic [2:0] MODE_CROSS = 3'd4;
  localparam logic [2:0] MODE_MAG   = 3'd5;

  // Four guard bits cover the worst-case kernel gain (magnitude of mode 5 and the diagonals).
  function automatic int sum_width(input int pix_w);
    return pix_w + 4;
  endfunction

  function automatic int clamp_limit(input int pix_w);
    return (1 << pix_w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_linebuf.sv
`default_nettype none
// sobel_linebuf: two-row shift RAM; each write pushes the old row-1 pixel at this column into row 2.
// Rev 1.0
module sobel_linebuf #(
  parameter int PIX_W  = 8,
  parameter int LINE_W = 64,
  parameter int AW     = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] row1,
  output logic [PIX_W-1:0] row2
);

  logic [PIX_W-1:0] mem1 [LINE_W];
  logic [PIX_W-1:0] mem2 [LINE_W];

  assign row1 = mem1[addr];
  assign row2 = mem2[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem1[addr] <= din;
      mem2[addr] <= mem1[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_stream.sv
`default_nettype none
// sobel_stream: streaming 3x3 edge kernels with a sum/clamp pipeline and a per-frame clamp counter.
// Rev 1.0
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int LINE_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PIX_W-1:0]        in_pix,
  input  logic                    in_sof,
  input  logic [2:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [PIX_W:0]   out_pix,
  output logic                    out_sat,
  output logic [CNT_W-1:0]        sat_cnt
);

  localparam int SW = sum_width(PIX_W);
  localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic signed [SW-1:0] LIM  = SW'(clamp_limit(PIX_W));
  localparam logic signed [SW-1:0] NLIM = -LIM;
  localparam logic [PIX_W:0] LIM_P = LIM[PIX_W:0];
  localparam logic [PIX_W:0] LIM_N = NLIM[PIX_W:0];

  typedef logic signed [SW-1:0] sum_t;

  function automatic sum_t ext(input logic [PIX_W-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  function automatic sum_t sabs(input sum_t v);
    return v[SW-1] ? -v : v;
  endfunction

  logic             advance, accept, produce, started, retire_sat;
  logic [AW-1:0]    col, wr_col;
  logic [1:0]       row;
  logic [2:0]       mode_r;
  logic [PIX_W-1:0] top_pix, mid_pix;
  logic [PIX_W-1:0] c1_top, c1_mid, c1_bot, c2_top, c2_mid, c2_bot;
  logic             s1_valid;
  sum_t             s1_sum, sum_next;
  sum_t             p0, p1, p2, p3, p4, p5, p6, p7, p8, k0, k1;

  assign advance    = !out_valid || out_ready;
  assign in_ready   = advance;
  assign accept     = in_valid && advance;
  assign wr_col     = in_sof ? '0 : col;
  assign produce    = started && !in_sof && (row == 2'd2) && (col >= AW'(2));
  assign retire_sat = out_valid && out_ready && out_sat;

  sobel_linebuf #(.PIX_W(PIX_W), .LINE_W(LINE_W), .AW(AW)) u_linebuf (
    .clk  (clk),
    .we   (accept),
    .addr (wr_col),
    .din  (in_pix),
    .row1 (mid_pix),
    .row2 (top_pix)
  );

  // Window columns: c2 = col-2, c1 = col-1, current column comes straight from the RAM and input.
  assign p0 = ext(c2_top);  assign p1 = ext(c1_top);  assign p2 = ext(top_pix);
  assign p3 = ext(c2_mid);  assign p4 = ext(c1_mid);  assign p5 = ext(mid_pix);
  assign p6 = ext(c2_bot);  assign p7 = ext(c1_bot);  assign p8 = ext(in_pix);

  assign k0 = (p2 + p5 + p5 + p8) - (p0 + p3 + p3 + p6);
  assign k1 = (p0 + p1 + p1 + p2) - (p6 + p7 + p7 + p8);

  always_comb begin
    sum_next = k0;
    case (mode_r)
      MODE_GY:    sum_next = k1;
      MODE_D45:   sum_next = (p0 + p1 + p3 + p0 + p1 + p3) - (p2 + p4 + p5 + p6 + p7 + p8);
      MODE_D135:  sum_next = (p1 + p2 + p5 + p1 + p2 + p5) - (p0 + p3 + p4 + p6 + p7 + p8);
      MODE_CROSS: sum_next = (p2 + p6) - (p0 + p8);
      MODE_MAG:   sum_next = sabs(k0) + sabs(k1);
      default:    sum_next = k0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started   <= 1'b0;
      col       <= '0;
      row       <= '0;
      mode_r    <= MODE_GX;
      c1_top    <= '0;  c1_mid <= '0;  c1_bot <= '0;
      c2_top    <= '0;  c2_mid <= '0;  c2_bot <= '0;
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_sat   <= 1'b0;
      sat_cnt   <= '0;
    end else begin
      if (accept) begin
        c2_top <= c1_top;   c2_mid <= c1_mid;   c2_bot <= c1_bot;
        c1_top <= top_pix;  c1_mid <= mid_pix;  c1_bot <= in_pix;
        if (in_sof) begin
          col     <= AW'(1);
          row     <= 2'd0;
          started <= 1'b1;
          mode_r  <= mode;
        end else if (started) begin
          if (col == AW'(LINE_W - 1)) begin
            col <= '0;
            if (row != 2'd2) row <= row + 2'd1;
          end else begin
            col <= col + AW'(1);
          end
        end
      end
      if (advance) begin
        s1_valid  <= accept && produce;
        s1_sum    <= sum_next;
        out_valid <= s1_valid;
        if (s1_sum > LIM) begin
          out_pix <= $signed(LIM_P);
          out_sat <= 1'b1;
        end else if (s1_sum < NLIM) begin
          out_pix <= $signed(LIM_N);
          out_sat <= 1'b1;
        end else begin
          out_pix <= s1_sum[PIX_W:0];
          out_sat <= 1'b0;
        end
      end
      // A saturated result retiring on the start-of-frame beat belongs to the new count.
      if (accept && in_sof)
        sat_cnt <= retire_sat ? CNT_W'(1) : '0;
      else if (retire_sat && !(&sat_cnt))
        sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream.sv
`default_nettype none
// tb_sobel_stream: directed and randomized frames checked against an image-level kernel model.
// Rev 1.0
module tb_sobel_stream;

  localparam int PIX_W  = 8;
  localparam int LINE_W = 64;
  localparam int CNT_W  = 16;
  localparam int H      = 8;
  localparam int NPIX   = H * LINE_W;
  localparam int LIM    = (1 << PIX_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic [PIX_W-1:0] in_pix = '0;
  logic [2:0] mode = '0;
  logic in_ready, out_valid, out_sat;
  logic signed [PIX_W:0] out_pix;
  logic [CNT_W-1:0] sat_cnt;

  always #5 clk = ~clk;

  sobel_stream #(.PIX_W(PIX_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .in_sof(in_sof), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_sat(out_sat), .sat_cnt(sat_cnt)
  );

  typedef struct packed { logic [PIX_W:0] pix; logic sat; } res_t;
  res_t exp_q[$];
  res_t rec_q[$];
  int   n_cmp = 0, n_err = 0;
  int   img [H][LINE_W];
  bit   rand_ready = 1'b0;
  bit   prev_stall = 1'b0;
  logic [PIX_W+1:0] prev_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Downstream: drive out_ready, check handshake rules, capture transfers.
  always @(negedge clk) begin
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #2;
    if (!rst) begin
      check("in_ready_rule", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
      if (prev_stall) check("hold_stable", {21'd0, out_valid, out_pix, out_sat}, {21'd0, 1'b1, prev_word});
      if (out_valid && out_ready) rec_q.push_back('{out_pix, out_sat});
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_pix, out_sat};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_pix(input int pix, input bit sof, input logic [2:0] m);
    int guard = 0;
    bit acc;
    @(negedge clk);
    in_valid = 1'b1;
    in_pix   = pix[PIX_W-1:0];
    in_sof   = sof;
    mode     = sof ? m : 3'($urandom_range(0, 7));
    #1 acc = in_ready;
    while (!acc && guard <= 1000) begin
      @(negedge clk);
      #1 acc = in_ready;
      guard++;
    end
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 1000 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int lo, input int hi, input logic [2:0] m);
    for (int idx = lo; idx < hi; idx++)
      send_pix(img[idx / LINE_W][idx % LINE_W], idx == 0, m);
  endtask

  // Reference: every interior pixel of the accepted prefix yields one clamped kernel value.
  task automatic model_frame(input int npix, input int m, output int nsat);
    int w[9];
    int k0, k1, v, r, c;
    res_t e;
    nsat = 0;
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / LINE_W;
      c = idx % LINE_W;
      if (r >= 2 && c >= 2) begin
        for (int k = 0; k < 9; k++) w[k] = img[r - 2 + k / 3][c - 2 + k % 3];
        k0 = -w[0] - 2*w[3] - w[6] + w[2] + 2*w[5] + w[8];
        k1 =  w[0] + 2*w[1] + w[2] - w[6] - 2*w[7] - w[8];
        case (m)
          1:       v = k1;
          2:       v = 2*(w[0] + w[1] + w[3]) - (w[2] + w[4] + w[5] + w[6] + w[7] + w[8]);
          3:       v = 2*(w[1] + w[2] + w[5]) - (w[0] + w[3] + w[4] + w[6] + w[7] + w[8]);
          4:       v = -w[0] + w[2] + w[6] - w[8];
          5:       v = (k0 < 0 ? -k0 : k0) + (k1 < 0 ? -k1 : k1);
          default: v = k0;
        endcase
        e.sat = (v > LIM) || (v < -LIM);
        if (v > LIM)  v = LIM;
        if (v < -LIM) v = -LIM;
        e.pix = (PIX_W+1)'(v);
        if (e.sat) nsat++;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain(input string tag, input int nsat);
    int g = 0;
    int n;
    while (rec_q.size() < exp_q.size() && g < 5000) begin
      @(posedge clk);
      g++;
    end
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_count"}, rec_q.size(), exp_q.size());
    n = (rec_q.size() < exp_q.size()) ? rec_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_pix"}, {23'd0, rec_q[i].pix}, {23'd0, exp_q[i].pix});
      check({tag, "_sat"}, {31'd0, rec_q[i].sat}, {31'd0, exp_q[i].sat});
    end
    check({tag, "_sat_cnt"}, {16'd0, sat_cnt}, nsat);
    exp_q.delete();
    rec_q.delete();
  endtask

  task automatic fill(input int kind, input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < LINE_W; c++)
        case (kind)
          0:       img[r][c] = v;
          1:       img[r][c] = (c < 32) ? 0 : 255;
          2:       img[r][c] = (r < 4) ? 0 : 200;
          default: img[r][c] = int'($urandom_range(0, LIM));
        endcase
  endtask

  initial begin
    int ns, ns_b, n_a;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_sat_cnt", {16'd0, sat_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_ready", {31'd0, in_ready}, 1);

    // Pixels before the first start of frame produce nothing
    for (int i = 0; i < 200; i++) send_pix(int'($urandom_range(0, LIM)), 1'b0, 3'd0);
    drain("pre_sof", 0);

    // Flat field in every mode, including the aliases 6 and 7
    for (int m = 0; m < 8; m++) begin
      fill(0, 100);
      model_frame(NPIX, m, ns);
      send_frame(0, NPIX, 3'(m));
      drain("flat", ns);
    end

    fill(1, 0); model_frame(NPIX, 0, ns); send_frame(0, NPIX, 3'd0); drain("vedge_gx", ns);
    check("vedge_sat_total", ns, 2 * (H - 2));
    fill(2, 0); model_frame(NPIX, 1, ns); send_frame(0, NPIX, 3'd1); drain("hedge_gy", ns);
    fill(2, 0); model_frame(NPIX, 5, ns); send_frame(0, NPIX, 3'd5); drain("hedge_mag", ns);

    // Random back-pressure and random images
    rand_ready = 1'b1;
    fill(2, 0); model_frame(NPIX, 1, ns); send_frame(0, NPIX, 3'd1); drain("bp_hedge", ns);
    for (int m = 0; m < 8; m++) begin
      fill(3, 0);
      model_frame(NPIX, m, ns);
      send_frame(0, NPIX, 3'(m));
      drain("bp_rand", ns);
    end
    rand_ready = 1'b0;

    // Start of frame arriving at row 5, col 10
    fill(1, 0);
    model_frame(5 * LINE_W + 10, 0, ns);
    n_a = exp_q.size();
    send_frame(0, 5 * LINE_W + 10, 3'd0);
    fill(3, 0);
    model_frame(NPIX, 4, ns_b);
    send_frame(0, 2 * LINE_W + 2, 3'd4);
    repeat (5) @(posedge clk);
    #1;
    check("midsof_no_early", rec_q.size(), n_a);
    check("midsof_sat_restart", {16'd0, sat_cnt}, 0);
    send_frame(2 * LINE_W + 2, NPIX, 3'd4);
    drain("midsof", ns_b);

    // Reset in the middle of a frame
    fill(1, 0);
    send_frame(0, 300, 3'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    check("midrst_sat_cnt", {16'd0, sat_cnt}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    rec_q.delete();
    #1 check("midrst_in_ready", {31'd0, in_ready}, 1);
    for (int i = 0; i < 150; i++) send_pix(int'($urandom_range(0, LIM)), 1'b0, 3'd0);
    drain("midrst_idle", 0);
    fill(3, 0); model_frame(NPIX, 3, ns); send_frame(0, NPIX, 3'd3); drain("midrst_new", ns);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
